display_time_decoder: RTL

//  Reads the seven-segment hour/minute/AM-PM display outputs of CORE and recovers binary time.
//  It is the decode direction of the convertor path.

---
 rtl/display_time_decoder.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/display_time_decoder.sv
// -----------------------------------------------------------------------------
// display_time_decoder
//
// Watches the seven-segment hour/minute/AM-PM display driven by CORE and turns
// it back into binary time. The raw display is sampled every cycle and must hold
// still for STABLE_CYCLES consecutive samples before it is considered. Each
// newly stable value is validated once. A legal value is published over a
// valid/ready handshake. An illegal value produces a one-cycle code_err pulse
// and bumps a saturating error counter.
//
// Segment encoding per digit is {g,f,e,d,c,b,a}, active-high:
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, blank=00
//   (blank is legal only in the hour tens position)
//
// Ports
//   CLOCK       in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   hr_seg      in   [13:7] hour tens, [6:0] hour units
//   min_seg     in   [13:7] minute tens, [6:0] minute units
//   am_pm_seg   in   1 = PM, 0 = AM
//   time_ready  in   consumer accepts time_* when high together with time_valid
//   time_valid  out  time_hr/time_min/time_pm hold a new decoded time
//   time_hr     out  hours 1..12
//   time_min    out  minutes 0..59
//   time_pm     out  PM flag
//   code_err    out  one-cycle pulse: a stable display value failed decode
//   err_count   out  saturating count of code_err pulses
//   overrun     out  sticky: a new stable value arrived while time_valid pending
// -----------------------------------------------------------------------------
module display_time_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 CLOCK,
    input  logic                 resetn,
    input  logic [13:0]          hr_seg,
    input  logic [13:0]          min_seg,
    input  logic                 am_pm_seg,
    input  logic                 time_ready,
    output logic                 time_valid,
    output logic [3:0]           time_hr,
    output logic [5:0]           time_min,
    output logic                 time_pm,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 overrun
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    localparam int DISP_W = 29;
    localparam int CNT_W  = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]     STAB_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ONE   = 7'h06;

    typedef enum logic [1:0] {
        SETTLE,
        CHECK,
        PUBLISH
    } state_t;

    // Result of decoding one seven-segment digit.
    typedef struct packed {
        logic       ok;
        logic [3:0] val;
    } digit_t;

    function automatic digit_t seg_digit(input logic [6:0] seg);
        digit_t d;
        d.ok  = 1'b1;
        d.val = 4'd0;
        case (seg)
            7'h3F:   d.val = 4'd0;
            7'h06:   d.val = 4'd1;
            7'h5B:   d.val = 4'd2;
            7'h4F:   d.val = 4'd3;
            7'h66:   d.val = 4'd4;
            7'h6D:   d.val = 4'd5;
            7'h7D:   d.val = 4'd6;
            7'h07:   d.val = 4'd7;
            7'h7F:   d.val = 4'd8;
            7'h6F:   d.val = 4'd9;
            default: d.ok  = 1'b0;
        endcase
        return d;
    endfunction

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [DISP_W-1:0] disp;          // {hr_seg, min_seg, am_pm_seg}
    logic [DISP_W-1:0] samp;          // previous-cycle display sample
    logic [CNT_W-1:0]  stab_cnt;      // consecutive equal samples, saturating
    logic              stab_full;
    logic              new_value;     // stable and not yet accepted

    logic [DISP_W-1:0] cand;          // value under validation in CHECK
    logic [DISP_W-1:0] pend;          // 1-deep pending value seen during PUBLISH
    logic              pend_valid;
    logic [DISP_W-1:0] last_acc;      // last value taken into CHECK
    logic              acc_valid;     // last_acc holds something since reset

    state_t            state;

    digit_t            hr_u;
    digit_t            mn_t;
    digit_t            mn_u;
    logic [6:0]        hr_tens_seg;
    logic              hr_legal;
    logic              min_legal;
    logic              dec_legal;
    logic [3:0]        dec_hr;
    logic [5:0]        dec_min;
    logic              handshake;

    assign disp = {hr_seg, min_seg, am_pm_seg};

    // -------------------------------------------------------------------------
    // Input stage: sample register and stability counter
    // -------------------------------------------------------------------------
    // NOTE: samp is a plain data pipe with no reset; stab_cnt (which is reset)
    // is the only thing that qualifies it, so an unknown samp is never used.
    always_ff @(posedge CLOCK) begin
        samp <= disp;
    end

    always_ff @(posedge CLOCK) begin
        if (!resetn) begin
            stab_cnt <= '0;
        end else if (disp != samp) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_cnt <= stab_cnt + CNT_W'(1);
        end
    end

    assign stab_full = (stab_cnt == STAB_MAX);

    // A value is "new" once it has settled and differs from the last one taken
    // into CHECK; comparing against last_acc is what suppresses repeats.
    assign new_value = stab_full && (!acc_valid || (samp != last_acc));

    assign handshake = time_valid && time_ready;

    // -------------------------------------------------------------------------
    // Combinational decode of the candidate value
    // cand layout: [28:22] hr tens, [21:15] hr units,
    //              [14:8]  min tens, [7:1] min units, [0] PM
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path through
    // the if/else tree leaves a value unassigned and infers a latch.
    always_comb begin
        hr_tens_seg = cand[28:22];
        hr_u        = seg_digit(cand[21:15]);
        mn_t        = seg_digit(cand[14:8]);
        mn_u        = seg_digit(cand[7:1]);

        hr_legal    = 1'b0;
        dec_hr      = 4'd0;

        if (hr_tens_seg == SEG_BLANK) begin
            // Single-digit hour: units must be 1..9.
            if (hr_u.ok && (hr_u.val != 4'd0)) begin
                hr_legal = 1'b1;
                dec_hr   = hr_u.val;
            end
        end else if (hr_tens_seg == SEG_ONE) begin
            // Two-digit hour: only 10, 11, 12.
            if (hr_u.ok && (hr_u.val <= 4'd2)) begin
                hr_legal = 1'b1;
                dec_hr   = 4'd10 + hr_u.val;
            end
        end

        // Blank is not a legal minute digit; seg_digit already rejects it.
        min_legal = mn_t.ok && (mn_t.val <= 4'd5) && mn_u.ok;
        dec_min   = (6'(mn_t.val) * 6'd10) + 6'(mn_u.val);

        dec_legal = hr_legal && min_legal;
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, independent of order.
    always_ff @(posedge CLOCK) begin
        if (!resetn) begin
            state      <= SETTLE;
            time_valid <= 1'b0;
            time_hr    <= 4'd0;
            time_min   <= 6'd0;
            time_pm    <= 1'b0;
            code_err   <= 1'b0;
            err_count  <= '0;
            overrun    <= 1'b0;
            pend_valid <= 1'b0;
            acc_valid  <= 1'b0;
        end else begin
            code_err <= 1'b0;

            case (state)
                SETTLE: begin
                    if (new_value) begin
                        cand  <= samp;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    // Recording bad values too means each one is flagged once.
                    last_acc  <= cand;
                    acc_valid <= 1'b1;
                    if (dec_legal) begin
                        time_hr    <= dec_hr;
                        time_min   <= dec_min;
                        time_pm    <= cand[0];
                        time_valid <= 1'b1;
                        state      <= PUBLISH;
                    end else begin
                        code_err <= 1'b1;
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_CNT_W'(1);
                        end
                        state <= SETTLE;
                    end
                end

                PUBLISH: begin
                    if (new_value) begin
                        overrun <= 1'b1;
                    end

                    if (handshake) begin
                        time_valid <= 1'b0;
                        pend_valid <= 1'b0;
                        // The live sample is at least as recent as pend.
                        if (new_value) begin
                            cand  <= samp;
                            state <= CHECK;
                        end else if (pend_valid) begin
                            cand  <= pend;
                            state <= CHECK;
                        end else begin
                            state <= SETTLE;
                        end
                    end else if (new_value) begin
                        // Later arrivals overwrite the single pending slot.
                        pend       <= samp;
                        pend_valid <= 1'b1;
                    end
                end

                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

endmodule
